// File: rtl/commit_trace_buffer_pkg.sv
// rtl/commit_trace_buffer_pkg.sv - shared types and constants for the retirement trace buffer
package commit_trace_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ARMED  = 2'b01,
        ST_POST   = 2'b10,
        ST_FROZEN = 2'b11
    } state_t;

    localparam logic [1:0] TRIG_NONE    = 2'b00;
    localparam logic [1:0] TRIG_PC      = 2'b01;
    localparam logic [1:0] TRIG_RD      = 2'b10;
    localparam logic [1:0] TRIG_RD_DATA = 2'b11;

    localparam int TRACE_XLEN = 32;
    localparam int TRACE_RA_W = 5;

    // Field order matches the packed storage word {pc, rd, data, reg_write}
    typedef struct packed {
        logic [TRACE_XLEN-1:0] pc;
        logic [TRACE_RA_W-1:0] rd;
        logic [TRACE_XLEN-1:0] data;
        logic                  reg_write;
    } trace_entry_t;

endpackage

// File: rtl/commit_trace_buffer_trace_ram.sv
// rtl/commit_trace_buffer_trace_ram.sv - trace storage with synchronous write and registered read
module trace_ram
    import commit_trace_buffer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 70
) (
    input  logic                     clk,
    input  logic                     i_clr,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read register holds its value between pops; only the output is cleared
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/commit_trace_buffer.sv
// rtl/commit_trace_buffer.sv - retirement trace capture buffer with trigger, post window and readout
module commit_trace_buffer
    import commit_trace_buffer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arm,
    input  logic             disarm,
    input  logic [1:0]       trig_mode,
    input  logic [XLEN-1:0]  trig_pc,
    input  logic [RA_W-1:0]  trig_rd,
    input  logic [XLEN-1:0]  trig_data,
    input  logic [CNT_W-1:0] post_count,
    input  logic             wb_valid,
    input  logic             wb_reg_write,
    input  logic [XLEN-1:0]  wb_pc,
    input  logic [RA_W-1:0]  wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             rd_req,
    output logic             rd_valid,
    output logic [XLEN-1:0]  rd_pc,
    output logic [RA_W-1:0]  rd_rd,
    output logic [XLEN-1:0]  rd_data,
    output logic             rd_reg_write,
    output logic [CNT_W-1:0] count,
    output logic [1:0]       state,
    output logic             triggered,
    output logic             overflow
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = 2 * XLEN + RA_W + 1;

    state_t           r_state;
    state_t           w_next_state;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_post_left;
    logic [CNT_W-1:0] w_next_post_left;
    logic             r_triggered;
    logic             r_overflow;
    logic             r_rd_valid;

    logic             w_active;
    logic             w_match;
    logic             w_capture;
    logic             w_hit;
    logic             w_pop;
    logic             w_full;
    logic [ENTRY_W-1:0] w_rdata;

    assign w_active = (r_state == ST_ARMED) || (r_state == ST_POST);
    assign w_full   = (r_count == CNT_W'(DEPTH));

    always_comb begin
        w_match = 1'b0;
        case (trig_mode)
            TRIG_PC:      w_match = (wb_pc == trig_pc);
            TRIG_RD:      w_match = (wb_rd == trig_rd) && wb_reg_write;
            TRIG_RD_DATA: w_match = (wb_rd == trig_rd) && wb_reg_write && (wb_data == trig_data);
            default:      w_match = 1'b0;
        endcase
    end

    // arm and disarm outrank the trigger; a disarm cycle still captures its entry
    assign w_capture = w_active && wb_valid && !arm;
    assign w_hit     = (r_state == ST_ARMED) && wb_valid && w_match && !arm && !disarm;
    assign w_pop     = ((r_state == ST_IDLE) || (r_state == ST_FROZEN)) && rd_req
                       && (r_count != '0) && !arm;

    always_comb begin
        w_next_state     = r_state;
        w_next_post_left = r_post_left;
        if (arm) begin
            w_next_state = ST_ARMED;
        end else if (disarm && w_active) begin
            w_next_state = ST_FROZEN;
        end else if (w_hit) begin
            if (post_count == '0) begin
                w_next_state = ST_FROZEN;
            end else begin
                w_next_state     = ST_POST;
                w_next_post_left = post_count;
            end
        end else if ((r_state == ST_POST) && wb_valid) begin
            w_next_post_left = r_post_left - CNT_W'(1);
            if (r_post_left == CNT_W'(1)) begin
                w_next_state = ST_FROZEN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_post_left <= '0;
            r_triggered <= 1'b0;
            r_overflow  <= 1'b0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_post_left <= w_next_post_left;
            r_rd_valid  <= w_pop;
            if (arm) begin
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_count     <= '0;
                r_triggered <= 1'b0;
                r_overflow  <= 1'b0;
            end else begin
                if (w_hit) begin
                    r_triggered <= 1'b1;
                end
                // When full the oldest entry is dropped so the newest DEPTH survive
                if (w_capture) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                    if (w_full) begin
                        r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
                        r_overflow <= 1'b1;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                    r_count  <= r_count - CNT_W'(1);
                end
            end
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_trace_ram (
        .clk     (clk),
        .i_clr   (reset | arm),
        .i_we    (w_capture && !reset),
        .i_waddr (r_wr_ptr),
        .i_wdata ({wb_pc, wb_rd, wb_data, wb_reg_write}),
        .i_re    (w_pop),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    assign {rd_pc, rd_rd, rd_data, rd_reg_write} = w_rdata;
    assign rd_valid  = r_rd_valid;
    assign count     = r_count;
    assign state     = r_state;
    assign triggered = r_triggered;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb/tb_commit_trace_buffer.sv - self-checking bench for commit_trace_buffer against a queue model
module tb_commit_trace_buffer;
    import commit_trace_buffer_pkg::*;

    localparam int DEPTH = 16;
    localparam int XLEN  = 32;
    localparam int RA_W  = 5;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             reset, arm, disarm;
    logic [1:0]       trig_mode;
    logic [XLEN-1:0]  trig_pc, trig_data;
    logic [RA_W-1:0]  trig_rd;
    logic [CNT_W-1:0] post_count;
    logic             wb_valid, wb_reg_write;
    logic [XLEN-1:0]  wb_pc, wb_data;
    logic [RA_W-1:0]  wb_rd;
    logic             rd_req;
    logic             rd_valid, rd_reg_write, triggered, overflow;
    logic [XLEN-1:0]  rd_pc, rd_data;
    logic [RA_W-1:0]  rd_rd;
    logic [CNT_W-1:0] count;
    logic [1:0]       state;

    int checks = 0;
    int errors = 0;

    trace_entry_t m_q[$];
    trace_entry_t m_rd;
    logic [1:0]   m_state;
    logic         m_trig, m_ovf, m_rdv;
    int           m_left;

    commit_trace_buffer #(.DEPTH(DEPTH), .XLEN(XLEN), .RA_W(RA_W)) dut (
        .clk(clk), .reset(reset), .arm(arm), .disarm(disarm),
        .trig_mode(trig_mode), .trig_pc(trig_pc), .trig_rd(trig_rd), .trig_data(trig_data),
        .post_count(post_count), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_pc(wb_pc), .wb_rd(wb_rd), .wb_data(wb_data), .rd_req(rd_req),
        .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_rd(rd_rd), .rd_data(rd_data),
        .rd_reg_write(rd_reg_write), .count(count), .state(state),
        .triggered(triggered), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference: the trace is a queue of at most DEPTH entries, oldest at the front
    task automatic model_step();
        logic [1:0]   old;
        logic         match;
        trace_entry_t e;
        if (reset || arm) begin
            m_q.delete();
            m_state = reset ? 2'b00 : 2'b01;
            m_trig = 0; m_ovf = 0; m_rdv = 0; m_rd = '0;
            return;
        end
        old = m_state;
        m_rdv = 0;
        case (trig_mode)
            2'b01:   match = (wb_pc == trig_pc);
            2'b10:   match = (wb_rd == trig_rd) && wb_reg_write;
            2'b11:   match = (wb_rd == trig_rd) && wb_reg_write && (wb_data == trig_data);
            default: match = 0;
        endcase
        if ((old == 2'b01 || old == 2'b10) && wb_valid) begin
            e.pc = wb_pc; e.rd = wb_rd; e.data = wb_data; e.reg_write = wb_reg_write;
            m_q.push_back(e);
            if (m_q.size() > DEPTH) begin
                void'(m_q.pop_front());
                m_ovf = 1;
            end
        end
        if (disarm && (old == 2'b01 || old == 2'b10)) begin
            m_state = 2'b11;
        end else if (old == 2'b01 && wb_valid && match) begin
            m_trig = 1;
            if (post_count == 0) m_state = 2'b11;
            else begin m_state = 2'b10; m_left = int'(post_count); end
        end else if (old == 2'b10 && wb_valid) begin
            m_left = m_left - 1;
            if (m_left == 0) m_state = 2'b11;
        end
        if ((old == 2'b00 || old == 2'b11) && rd_req && m_q.size() > 0) begin
            m_rd = m_q.pop_front();
            m_rdv = 1;
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        reset = 0; arm = 0; disarm = 0; wb_valid = 0; rd_req = 0;
    endtask

    task automatic retire(input logic [XLEN-1:0] pc, input logic [RA_W-1:0] rd,
                          input logic [XLEN-1:0] data, input logic rw);
        wb_valid = 1; wb_pc = pc; wb_rd = rd; wb_data = data; wb_reg_write = rw;
        step();
    endtask

    task automatic do_arm(input logic [1:0] mode, input logic [XLEN-1:0] pc,
                          input logic [RA_W-1:0] rd, input logic [XLEN-1:0] data,
                          input logic [CNT_W-1:0] post);
        trig_mode = mode; trig_pc = pc; trig_rd = rd; trig_data = data; post_count = post;
        arm = 1;
        step();
    endtask

    task automatic test_reset();
        reset = 1;
        step();
        checks++;
        if ({state, count, triggered, overflow, rd_valid} !== {2'b00, 5'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_status got st=%0d cnt=%0d trg=%b ovf=%b rv=%b exp 0/0/0/0/0",
                     state, count, triggered, overflow, rd_valid);
        end
        checks++;
        if ({rd_pc, rd_rd, rd_data, rd_reg_write} !== '0) begin
            errors++;
            $display("FAIL reset_rd_fields got pc=%h rd=%0d data=%h rw=%b exp all zero",
                     rd_pc, rd_rd, rd_data, rd_reg_write);
        end
    endtask

    task automatic test_pc_trigger();
        do_arm(TRIG_PC, 32'h10, '0, '0, 5'd2);
        for (int i = 1; i <= 7; i++) retire(32'(i * 4), 5'd1, 32'(i * 4) ^ 32'h55, 1'b1);
        checks++;
        if ({state, count, triggered, overflow} !== {2'b11, 5'd6, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL pc_trig_freeze got st=%0d cnt=%0d trg=%b ovf=%b exp 3/6/1/0",
                     state, count, triggered, overflow);
        end
        for (int i = 1; i <= 6; i++) begin
            rd_req = 1;
            step();
            checks++;
            if (rd_valid !== 1'b1 || rd_pc !== 32'(i * 4) || rd_data !== (32'(i * 4) ^ 32'h55)) begin
                errors++;
                $display("FAIL pc_trig_pop%0d got v=%b pc=%h data=%h exp v=1 pc=%h", i, rd_valid,
                         rd_pc, rd_data, 32'(i * 4));
            end
        end
        rd_req = 1;
        step();
        checks++;
        if (rd_valid !== 1'b0 || count !== 5'd0) begin
            errors++;
            $display("FAIL pc_trig_empty got v=%b cnt=%0d exp v=0 cnt=0", rd_valid, count);
        end
    endtask

    task automatic test_overflow();
        do_arm(TRIG_NONE, '0, '0, '0, '0);
        for (int i = 1; i <= 20; i++) retire(32'(i * 4), 5'(i), 32'(i * 100), 1'b1);
        disarm = 1;
        step();
        checks++;
        if ({state, count, overflow, triggered} !== {2'b11, 5'd16, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL ovf_status got st=%0d cnt=%0d ovf=%b trg=%b exp 3/16/1/0",
                     state, count, overflow, triggered);
        end
        for (int i = 0; i < 16; i++) begin
            rd_req = 1;
            step();
            checks++;
            if (rd_valid !== 1'b1 || rd_pc !== 32'((i + 5) * 4) || rd_rd !== 5'(i + 5)) begin
                errors++;
                $display("FAIL ovf_pop%0d got v=%b pc=%h rd=%0d exp v=1 pc=%h rd=%0d", i, rd_valid,
                         rd_pc, rd_rd, 32'((i + 5) * 4), i + 5);
            end
        end
    endtask

    task automatic test_rd_data();
        do_arm(TRIG_RD_DATA, '0, 5'd5, 32'hDEADBEEF, 5'd0);
        retire(32'h100, 5'd5, 32'hCAFEBABE, 1'b1);
        checks++;
        if (state !== 2'b01 || triggered !== 1'b0) begin
            errors++;
            $display("FAIL rd_data_nohit got st=%0d trg=%b exp 1/0", state, triggered);
        end
        retire(32'h104, 5'd5, 32'hDEADBEEF, 1'b1);
        checks++;
        if ({state, count, triggered} !== {2'b11, 5'd2, 1'b1}) begin
            errors++;
            $display("FAIL rd_data_hit got st=%0d cnt=%0d trg=%b exp 3/2/1", state, count, triggered);
        end
    endtask

    task automatic test_rd_no_write();
        do_arm(TRIG_RD, '0, 5'd8, '0, 5'd0);
        retire(32'h200, 5'd8, 32'h1, 1'b0);
        checks++;
        if ({state, count, triggered} !== {2'b01, 5'd1, 1'b0}) begin
            errors++;
            $display("FAIL rd_nowrite got st=%0d cnt=%0d trg=%b exp 1/1/0", state, count, triggered);
        end
        disarm = 1;
        step();
    endtask

    task automatic test_single_pop();
        int pulses = 0;
        do_arm(TRIG_PC, 32'h40, '0, '0, 5'd0);
        retire(32'h40, 5'd3, 32'h77, 1'b1);
        checks++;
        if (state !== 2'b11 || count !== 5'd1) begin
            errors++;
            $display("FAIL single_setup got st=%0d cnt=%0d exp 3/1", state, count);
        end
        for (int i = 0; i < 3; i++) begin
            rd_req = 1;
            step();
            if (rd_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1 || count !== 5'd0 || rd_pc !== 32'h40) begin
            errors++;
            $display("FAIL single_pop got pulses=%0d cnt=%0d pc=%h exp 1/0/40", pulses, count, rd_pc);
        end
    endtask

    task automatic test_reset_mid_post();
        do_arm(TRIG_PC, 32'h10, '0, '0, 5'd3);
        retire(32'h10, 5'd1, 32'h1, 1'b1);
        retire(32'h14, 5'd1, 32'h2, 1'b1);
        checks++;
        if (state !== 2'b10) begin
            errors++;
            $display("FAIL mid_post_state got %0d exp 2", state);
        end
        reset = 1;
        step();
        checks++;
        if ({state, count, triggered} !== {2'b00, 5'd0, 1'b0}) begin
            errors++;
            $display("FAIL mid_post_reset got st=%0d cnt=%0d trg=%b exp 0/0/0", state, count, triggered);
        end
        arm = 1;
        rd_req = 1;
        step();
        checks++;
        if (state !== 2'b01 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL arm_vs_rdreq got st=%0d rv=%b exp 1/0", state, rd_valid);
        end
    endtask

    task automatic test_random();
        for (int ep = 0; ep < 12; ep++) begin
            do_arm(2'($urandom_range(0, 3)), 32'($urandom_range(0, 7) * 4), 5'($urandom_range(0, 3)),
                   32'($urandom_range(0, 3)), 5'($urandom_range(0, DEPTH - 1)));
            for (int c = 0; c < 90; c++) begin
                if (c < 60) begin
                    wb_valid     = ($urandom_range(0, 3) != 0);
                    wb_pc        = 32'($urandom_range(0, 7) * 4);
                    wb_rd        = 5'($urandom_range(0, 3));
                    wb_data      = 32'($urandom_range(0, 3));
                    wb_reg_write = 1'($urandom_range(0, 1));
                    disarm       = ($urandom_range(0, 40) == 0);
                    arm          = ($urandom_range(0, 90) == 0);
                end
                if (c == 60) disarm = 1;
                rd_req = ($urandom_range(0, 2) != 0);
                step();
                checks++;
                if ({state, count, triggered, overflow, rd_valid} !==
                    {m_state, CNT_W'(m_q.size()), m_trig, m_ovf, m_rdv}) begin
                    errors++;
                    $display("FAIL rand_status ep%0d c%0d got st=%0d cnt=%0d trg=%b ovf=%b rv=%b exp st=%0d cnt=%0d trg=%b ovf=%b rv=%b",
                             ep, c, state, count, triggered, overflow, rd_valid,
                             m_state, m_q.size(), m_trig, m_ovf, m_rdv);
                end
                checks++;
                if ({rd_pc, rd_rd, rd_data, rd_reg_write} !== m_rd) begin
                    errors++;
                    $display("FAIL rand_rd ep%0d c%0d got pc=%h rd=%0d data=%h rw=%b exp pc=%h rd=%0d data=%h rw=%b",
                             ep, c, rd_pc, rd_rd, rd_data, rd_reg_write,
                             m_rd.pc, m_rd.rd, m_rd.data, m_rd.reg_write);
                end
            end
        end
    endtask

    initial begin
        reset = 1; arm = 0; disarm = 0; trig_mode = '0; trig_pc = '0; trig_rd = '0;
        trig_data = '0; post_count = '0; wb_valid = 0; wb_reg_write = 0; wb_pc = '0;
        wb_rd = '0; wb_data = '0; rd_req = 0;
        m_state = 2'b00; m_trig = 0; m_ovf = 0; m_rdv = 0; m_rd = '0; m_left = 0;
        test_reset();
        test_pc_trigger();
        test_overflow();
        test_rd_data();
        test_rd_no_write();
        test_single_pop();
        test_reset_mid_post();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
